sys_top: RTL and testbench

SYS_TOP -- requirements
Module: sys_top

---
 rtl/sys_top.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_sys_top.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_top.sv
// sys_top: UART-controlled register file and ALU.
// RX decodes 11-bit frames (start, data LSB first, even parity, stop) into bytes,
// a command FSM interprets them (write / read / load+exec / exec), and TX returns
// read data or ALU results as frames, back to back.
module sys_top #(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_DEPTH      = 16,
  parameter int REG_FILE_ADDR_WIDTH = $clog2(REG_FILE_DEPTH),
  parameter int CLKS_PER_BIT        = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  output logic TX_OUT,
  output logic par_err,
  output logic stp_err,
  output logic strt_glitch
);

  localparam int LAST_BIT   = FRAME_WIDTH + 2;
  localparam int BIT_W      = $clog2(LAST_BIT + 1);
  localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RES_FRAMES = (ALU_DATA_WIDTH + FRAME_WIDTH - 1) / FRAME_WIDTH;
  localparam int BUF_W      = RES_FRAMES * FRAME_WIDTH;
  localparam int LEFT_W     = $clog2(RES_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LAST_BIT);
  localparam logic [BIT_W-1:0] BIT_PAR  = BIT_W'(FRAME_WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_DMAX = BIT_W'(FRAME_WIDTH);

  localparam logic [FRAME_WIDTH-1:0] CMD_WR   = FRAME_WIDTH'(8'hAA);
  localparam logic [FRAME_WIDTH-1:0] CMD_RD   = FRAME_WIDTH'(8'hBB);
  localparam logic [FRAME_WIDTH-1:0] CMD_LDEX = FRAME_WIDTH'(8'hCC);
  localparam logic [FRAME_WIDTH-1:0] CMD_EX   = FRAME_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_FUNC, S_EXEC, S_SEND
  } state_t;

  // ---------------- receiver ----------------
  logic                   rx_prev_q, rx_prev_d;
  logic                   rx_busy_q, rx_busy_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [FRAME_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                   rx_par_q, rx_par_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;
  logic                   glitch_q, glitch_d;

  // ---------------- transmitter ----------------
  logic                   tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [FRAME_WIDTH+1:0] tx_shift_q, tx_shift_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_ready, tx_valid, tx_load;
  logic [FRAME_WIDTH-1:0] tx_data;

  // ---------------- command FSM / datapath ----------------
  state_t                        state_q, state_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ALU_FUNC_WIDTH-1:0]     func_q, func_d;
  logic [BUF_W-1:0]              send_buf_q, send_buf_d;
  logic [LEFT_W-1:0]             send_left_q, send_left_d;
  logic                          rf_we;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_waddr;
  logic [FRAME_WIDTH-1:0]        rf_wdata;
  logic [FRAME_WIDTH-1:0]        reg_q [REG_FILE_DEPTH];
  logic [ALU_DATA_WIDTH-1:0]     alu_a, alu_b, alu_res;

  assign TX_OUT      = tx_out_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = glitch_q;

  // RX next state: start on a falling edge while idle, sample every bit at mid-period.
  always_comb begin
    rx_prev_d  = RX_IN;
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    glitch_d   = 1'b0;
    if (!rx_busy_q) begin
      // The edge cycle itself counts as cycle 0 of the start bit.
      if (rx_prev_q && !RX_IN) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = CNT_W'(1);
        rx_bit_d  = '0;
      end
    end else begin
      if (rx_cnt_q == CNT_MAX) begin
        rx_cnt_d = '0;
        rx_bit_d = rx_bit_q + BIT_W'(1);
      end else begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      if (rx_cnt_q == CNT_HALF) begin
        if (rx_bit_q == '0) begin
          if (RX_IN) begin
            glitch_d  = 1'b1;
            rx_busy_d = 1'b0;
          end
        end else if (rx_bit_q <= BIT_DMAX) begin
          rx_shift_d = {RX_IN, rx_shift_q[FRAME_WIDTH-1:1]};
        end else if (rx_bit_q == BIT_PAR) begin
          rx_par_d = RX_IN;
        end else begin
          rx_busy_d  = 1'b0;
          par_err_d  = (rx_par_q != ^rx_shift_q);
          stp_err_d  = !RX_IN;
          rx_valid_d = (rx_par_q == ^rx_shift_q) && RX_IN;
        end
      end
    end
  end

  // TX accepts a new byte when idle or in the very last cycle of a stop bit.
  assign tx_ready = !tx_busy_q || ((tx_cnt_q == CNT_MAX) && (tx_bit_q == BIT_LAST));
  assign tx_load  = tx_valid && tx_ready;

  // TX next state: start bit on load, then shift data, parity, stop.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    if (tx_load) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_out_d   = 1'b0;
      tx_shift_d = {1'b1, ^tx_data, tx_data};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CNT_MAX) begin
        tx_cnt_d = '0;
        if (tx_bit_q == BIT_LAST) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + BIT_W'(1);
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[FRAME_WIDTH+1:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end
  end

  assign alu_a = ALU_DATA_WIDTH'(reg_q[0]);
  assign alu_b = ALU_DATA_WIDTH'(reg_q[1]);

  // ALU on zero-extended REG0 / REG1, result modulo 2^ALU_DATA_WIDTH.
  always_comb begin
    alu_res = '0;
    case (func_q)
      ALU_FUNC_WIDTH'(0):  alu_res = alu_a + alu_b;
      ALU_FUNC_WIDTH'(1):  alu_res = alu_a - alu_b;
      ALU_FUNC_WIDTH'(2):  alu_res = alu_a * alu_b;
      ALU_FUNC_WIDTH'(3):  alu_res = (alu_b == '0) ? '0 : alu_a / alu_b;
      ALU_FUNC_WIDTH'(4):  alu_res = alu_a & alu_b;
      ALU_FUNC_WIDTH'(5):  alu_res = alu_a | alu_b;
      ALU_FUNC_WIDTH'(6):  alu_res = ~(alu_a & alu_b);
      ALU_FUNC_WIDTH'(7):  alu_res = ~(alu_a | alu_b);
      ALU_FUNC_WIDTH'(8):  alu_res = alu_a ^ alu_b;
      ALU_FUNC_WIDTH'(9):  alu_res = ~(alu_a ^ alu_b);
      ALU_FUNC_WIDTH'(10): alu_res = (alu_a == alu_b) ? ALU_DATA_WIDTH'(1) : '0;
      ALU_FUNC_WIDTH'(11): alu_res = (alu_a >  alu_b) ? ALU_DATA_WIDTH'(2) : '0;
      ALU_FUNC_WIDTH'(12): alu_res = (alu_a <  alu_b) ? ALU_DATA_WIDTH'(3) : '0;
      ALU_FUNC_WIDTH'(13): alu_res = alu_a >> 1;
      ALU_FUNC_WIDTH'(14): alu_res = alu_a << 1;
      default:             alu_res = '0;
    endcase
  end

  // Command FSM: consumes delivered bytes, drives the register write port and TX.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    func_d      = func_q;
    send_buf_d  = send_buf_q;
    send_left_d = send_left_q;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    tx_valid    = 1'b0;
    tx_data     = send_buf_q[FRAME_WIDTH-1:0];
    case (state_q)
      S_IDLE: if (rx_valid_q) begin
        if (rx_shift_q == CMD_WR)        state_d = S_WR_ADDR;
        else if (rx_shift_q == CMD_RD)   state_d = S_RD_ADDR;
        else if (rx_shift_q == CMD_LDEX) state_d = S_OPA;
        else if (rx_shift_q == CMD_EX)   state_d = S_FUNC;
      end
      S_WR_ADDR: if (rx_valid_q) begin
        addr_d  = rx_shift_q[REG_FILE_ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = addr_q;
        rf_wdata = rx_shift_q;
        state_d  = S_IDLE;
      end
      S_RD_ADDR: if (rx_valid_q) begin
        send_buf_d  = BUF_W'(reg_q[rx_shift_q[REG_FILE_ADDR_WIDTH-1:0]]);
        send_left_d = LEFT_W'(1);
        state_d     = S_SEND;
      end
      S_OPA: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = REG_FILE_ADDR_WIDTH'(0);
        rf_wdata = rx_shift_q;
        state_d  = S_OPB;
      end
      S_OPB: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = REG_FILE_ADDR_WIDTH'(1);
        rf_wdata = rx_shift_q;
        state_d  = S_FUNC;
      end
      S_FUNC: if (rx_valid_q) begin
        func_d  = rx_shift_q[ALU_FUNC_WIDTH-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        send_buf_d  = BUF_W'(alu_res);
        send_left_d = LEFT_W'(RES_FRAMES);
        state_d     = S_SEND;
      end
      S_SEND: begin
        // Low byte goes first; leave only after the final stop bit has gone out.
        if (send_left_q != '0) begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            send_buf_d  = send_buf_q >> FRAME_WIDTH;
            send_left_d = send_left_q - LEFT_W'(1);
          end
        end else if (!tx_busy_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; the edge detector history resets low so a line held low
  // through reset release is not mistaken for a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_prev_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      glitch_q    <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
      tx_out_q    <= 1'b1;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      func_q      <= '0;
      send_buf_q  <= '0;
      send_left_q <= '0;
    end else begin
      rx_prev_q   <= rx_prev_d;
      rx_busy_q   <= rx_busy_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_valid_q  <= rx_valid_d;
      par_err_q   <= par_err_d;
      stp_err_q   <= stp_err_d;
      glitch_q    <= glitch_d;
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      func_q      <= func_d;
      send_buf_q  <= send_buf_d;
      send_left_q <= send_left_d;
    end
  end

  // Register file entries; REG0/REG1 feed the ALU directly so these are flops.
  for (genvar gi = 0; gi < REG_FILE_DEPTH; gi++) begin : g_rf
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        reg_q[gi] <= '0;
      end else if (rf_we && (rf_waddr == REG_FILE_ADDR_WIDTH'(gi))) begin
        reg_q[gi] <= rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sys_top.sv
// tb_sys_top: directed command vectors over the UART link with decoded TX frames.
module tb_sys_top;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RX_IN = 1'b1;
  logic TX_OUT, par_err, stp_err, strt_glitch;

  sys_top dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .TX_OUT(TX_OUT),
    .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Flag / line activity counters, sampled mid-cycle.
  int par_cnt = 0, stp_cnt = 0, gl_cnt = 0, txlow_cnt = 0;
  always @(negedge CLK) begin
    if (par_err === 1'b1) par_cnt <= par_cnt + 1;
    if (stp_err === 1'b1) stp_cnt <= stp_cnt + 1;
    if (strt_glitch === 1'b1) gl_cnt <= gl_cnt + 1;
    if (TX_OUT === 1'b0) txlow_cnt <= txlow_cnt + 1;
  end

  // TX frame decoder: samples each bit near its middle.
  typedef struct packed { logic st; logic [7:0] d; logic p; logic sp; } frm_t;
  frm_t fq[$];
  int   tq[$];
  initial begin : mon
    frm_t f;
    int t0;
    forever begin
      @(negedge CLK);
      if (TX_OUT === 1'b0) begin
        t0 = cyc;
        repeat (7) @(negedge CLK);
        f.st = TX_OUT;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge CLK);
          f.d[i] = TX_OUT;
        end
        repeat (16) @(negedge CLK);
        f.p = TX_OUT;
        repeat (16) @(negedge CLK);
        f.sp = TX_OUT;
        fq.push_back(f);
        tq.push_back(t0);
      end
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic pflip, input logic stopv);
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (16) @(negedge CLK);
    end
    RX_IN = (^d) ^ pflip;
    repeat (16) @(negedge CLK);
    RX_IN = stopv;
    repeat (16) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b1);
  endtask

  // Check the response queue against up to two expected bytes.
  task automatic chk_resp(input string nm, input int n, input logic [15:0] ob);
    chk({nm, " nframes"}, fq.size(), n);
    for (int k = 0; k < n && k < fq.size(); k++) begin
      chk($sformatf("%s f%0d data", nm, k), fq[k].d, ob[15-8*k -: 8]);
      chk($sformatf("%s f%0d start", nm, k), fq[k].st, 1'b0);
      chk($sformatf("%s f%0d parity", nm, k), fq[k].p, ^fq[k].d);
      chk($sformatf("%s f%0d stop", nm, k), fq[k].sp, 1'b1);
    end
    if (n == 2 && fq.size() == 2) chk({nm, " gap"}, tq[1] - tq[0], 176);
  endtask

  typedef struct { int n_in; logic [31:0] in_b; int n_out; logic [15:0] out_b; } vec_t;
  localparam int NV = 30;
  vec_t vt[NV];

  function automatic vec_t mk(int ni, logic [31:0] ib, int no, logic [15:0] ob);
    vec_t r;
    r.n_in = ni; r.in_b = ib; r.n_out = no; r.out_b = ob;
    return r;
  endfunction

  int p0, s0, g0, l0;

  initial begin
    vt[0]  = mk(2, 32'hBB05_0000, 1, 16'h0000);
    vt[1]  = mk(3, 32'hAA03_5A00, 0, 16'h0000);
    vt[2]  = mk(2, 32'hBB03_0000, 1, 16'h5A00);
    vt[3]  = mk(4, 32'hCC0C_0A02, 2, 16'h7800);
    vt[4]  = mk(2, 32'hDD01_0000, 2, 16'h0200);
    vt[5]  = mk(2, 32'hDD0B_0000, 2, 16'h0200);
    vt[6]  = mk(3, 32'hAA00_0700, 0, 16'h0000);
    vt[7]  = mk(3, 32'hAA01_0000, 0, 16'h0000);
    vt[8]  = mk(2, 32'hDD03_0000, 2, 16'h0000);
    vt[9]  = mk(4, 32'hCC0F_0306, 2, 16'hFCFF);
    vt[10] = mk(4, 32'hCCFF_FF02, 2, 16'h01FE);
    vt[11] = mk(4, 32'hCC10_0501, 2, 16'h0B00);
    vt[12] = mk(4, 32'hCC05_1001, 2, 16'hF5FF);
    vt[13] = mk(2, 32'hDD0C_0000, 2, 16'h0300);
    vt[14] = mk(2, 32'hDD0E_0000, 2, 16'h0A00);
    vt[15] = mk(2, 32'hDD0D_0000, 2, 16'h0200);
    vt[16] = mk(2, 32'hDD0A_0000, 2, 16'h0000);
    vt[17] = mk(2, 32'hDD07_0000, 2, 16'hEAFF);
    vt[18] = mk(4, 32'hCC64_0703, 2, 16'h0E00);
    vt[19] = mk(2, 32'hDD09_0000, 2, 16'h9CFF);
    vt[20] = mk(2, 32'hDD00_0000, 2, 16'h6B00);
    vt[21] = mk(2, 32'hDD08_0000, 2, 16'h6300);
    vt[22] = mk(2, 32'hDD04_0000, 2, 16'h0400);
    vt[23] = mk(2, 32'hDD05_0000, 2, 16'h6700);
    vt[24] = mk(2, 32'hDD0F_0000, 2, 16'h0000);
    vt[25] = mk(2, 32'hDDFB_0000, 2, 16'h0200);
    vt[26] = mk(2, 32'hBB00_0000, 1, 16'h6400);
    vt[27] = mk(3, 32'hAA1F_3300, 0, 16'h0000);
    vt[28] = mk(2, 32'hBB0F_0000, 1, 16'h3300);
    vt[29] = mk(2, 32'hBB01_0000, 1, 16'h0700);

    // Reset: low for 10 ns.
    #1 RST = 1'b0;
    #5;
    chk("reset TX_OUT", TX_OUT, 1'b1);
    chk("reset par_err", par_err, 1'b0);
    chk("reset stp_err", stp_err, 1'b0);
    chk("reset strt_glitch", strt_glitch, 1'b0);
    #5 RST = 1'b1;
    repeat (5) @(negedge CLK);
    $display("reset released at cycle %0d", cyc);

    // Table-driven command vectors.
    for (int v = 0; v < NV; v++) begin
      fq.delete(); tq.delete();
      for (int b = 0; b < vt[v].n_in; b++) send(vt[v].in_b[31-8*b -: 8]);
      repeat (400) @(negedge CLK);
      $display("vec %0d: sent %0d bytes %h, frames seen %0d", v, vt[v].n_in, vt[v].in_b, fq.size());
      chk_resp($sformatf("vec%0d", v), vt[v].n_out, vt[v].out_b);
    end

    // Parity error inside a read command leaves the FSM waiting for the address.
    send(8'hAA); send(8'h02); send(8'hC3);
    repeat (50) @(negedge CLK);
    fq.delete(); tq.delete();
    p0 = par_cnt; s0 = stp_cnt;
    send(8'hBB);
    send_byte(8'h55, 1'b1, 1'b1);
    chk("parerr par pulse", par_cnt - p0, 1);
    chk("parerr stp none", stp_cnt - s0, 0);
    send(8'h02);
    repeat (400) @(negedge CLK);
    $display("parity-error sequence: frames seen %0d", fq.size());
    chk_resp("parerr read", 1, 16'hC300);

    // Stop-bit errors (one alone, one together with parity) are discarded.
    p0 = par_cnt; s0 = stp_cnt;
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    repeat (20) @(negedge CLK);
    chk("stperr stp pulses", stp_cnt - s0, 2);
    chk("stperr par pulses", par_cnt - p0, 1);
    fq.delete(); tq.delete();
    send(8'hBB); send(8'h02);
    repeat (400) @(negedge CLK);
    $display("stop-error sequence: frames seen %0d", fq.size());
    chk_resp("stperr read", 1, 16'hC300);

    // False start: line low for 4 cycles.
    fq.delete(); tq.delete();
    g0 = gl_cnt; l0 = txlow_cnt;
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (300) @(negedge CLK);
    $display("glitch sequence: glitch pulses %0d", gl_cnt - g0);
    chk("glitch pulse", gl_cnt - g0, 1);
    chk("glitch tx idle", txlow_cnt - l0, 0);
    chk("glitch no frames", fq.size(), 0);

    // Bytes arriving while the result is being sent are dropped.
    fq.delete(); tq.delete();
    send(8'hCC); send(8'h01); send(8'h02); send(8'h00);
    send(8'hAA);
    repeat (400) @(negedge CLK);
    send(8'h02); send(8'h77);
    repeat (100) @(negedge CLK);
    $display("drop-during-send sequence: frames seen %0d", fq.size());
    chk_resp("dropsend result", 2, 16'h0300);
    fq.delete(); tq.delete();
    send(8'hBB); send(8'h02);
    repeat (400) @(negedge CLK);
    chk_resp("dropsend reg2", 1, 16'hC300);

    // Reset in the middle of a TX frame, RX held low across release.
    fq.delete(); tq.delete();
    send(8'hBB); send(8'h02);
    repeat (60) @(negedge CLK);
    chk("midrst tx busy", TX_OUT, 1'b0);
    RX_IN = 1'b0;
    RST = 1'b0;
    #1;
    chk("midrst TX_OUT", TX_OUT, 1'b1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    g0 = gl_cnt;
    repeat (5) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    l0 = txlow_cnt;
    repeat (400) @(negedge CLK);
    $display("mid-frame reset sequence: glitches %0d, tx low cycles %0d", gl_cnt - g0, txlow_cnt - l0);
    chk("midrst no glitch", gl_cnt - g0, 0);
    chk("midrst tx quiet", txlow_cnt - l0, 0);
    fq.delete(); tq.delete();
    send(8'hBB); send(8'h02);
    repeat (400) @(negedge CLK);
    chk_resp("midrst reg2 cleared", 1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
